// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - bank of leaky integrate-and-fire neurons sharing one time-step generator
module lif_neuron_array #(
    parameter int N_CH       = 4,
    parameter int W          = 8,
    parameter int DIV_W      = 26,
    parameter int DIV_MAX    = 49_999_999,
    parameter int REFRACT    = 2,
    parameter int LEAK_SHIFT = 1,
    parameter int LEAK_SUB   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] cur_in,
    input  logic [W-1:0]      thr,
    input  logic [1:0]        leak_mode,
    input  logic              soft_reset,
    input  logic              ext_tick_en,
    input  logic              step_in,
    output logic [N_CH-1:0]   spike,
    output logic              tick,
    output logic              heartbeat
);

    localparam int RW = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);

    logic [DIV_W-1:0] div;
    logic             step;

    // The divider sits at 0 in external mode, so resuming internal mode
    // starts a fresh period and cannot produce a step on the switch cycle.
    assign step = ext_tick_en ? step_in : (div == DIV_W'(DIV_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div       <= '0;
            tick      <= 1'b0;
            heartbeat <= 1'b0;
        end else begin
            if (ext_tick_en || step) begin
                div <= '0;
            end else begin
                div <= div + DIV_W'(1);
            end
            tick <= step;
            if (step) begin
                heartbeat <= ~heartbeat;
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [W-1:0]  u;
        logic [RW-1:0] refr;
        logic          fired;
        logic [W-1:0]  cur;
        logic [W-1:0]  leaked;
        logic [W:0]    sum;
        logic [W-1:0]  sat;

        assign cur = cur_in[k*W +: W];

        always_comb begin
            leaked = u;
            case (leak_mode)
                2'd0:    leaked = u - (u >> LEAK_SHIFT);
                2'd1:    leaked = (u > W'(LEAK_SUB)) ? u - W'(LEAK_SUB) : '0;
                default: leaked = u;
            endcase
        end

        // One extra bit catches the carry so the sum clamps instead of wrapping.
        assign sum = {1'b0, leaked} + {1'b0, cur};
        assign sat = sum[W] ? '1 : sum[W-1:0];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                u     <= '0;
                refr  <= '0;
                fired <= 1'b0;
            end else if (step) begin
                if (refr != '0) begin
                    refr  <= refr - RW'(1);
                    fired <= 1'b0;
                end else if (sat >= thr) begin
                    fired <= 1'b1;
                    refr  <= RW'(REFRACT);
                    u     <= soft_reset ? sat - thr : '0;
                end else begin
                    fired <= 1'b0;
                    u     <= sat;
                end
            end
        end

        assign spike[k] = fired;
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - directed and randomized check of lif_neuron_array against an arithmetic model
module tb_lif_neuron_array;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int DM = 3;
    localparam int RF = 2;
    localparam int LS = 1;
    localparam int LB = 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N*W-1:0] cur_in = '0;
    logic [W-1:0] thr = 8'd255;
    logic [1:0]   leak_mode = 2'd2;
    logic         soft_reset = 1'b0;
    logic         ext_tick_en = 1'b0;
    logic         step_in = 1'b0;
    logic [N-1:0] spike;
    logic         tick;
    logic         heartbeat;

    lif_neuron_array #(
        .N_CH(N), .W(W), .DIV_W(4), .DIV_MAX(DM),
        .REFRACT(RF), .LEAK_SHIFT(LS), .LEAK_SUB(LB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cur_in(cur_in), .thr(thr),
        .leak_mode(leak_mode), .soft_reset(soft_reset),
        .ext_tick_en(ext_tick_en), .step_in(step_in),
        .spike(spike), .tick(tick), .heartbeat(heartbeat)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    int mu[N];
    int mr[N];
    bit ms[N];
    bit mtick;
    bit mhb;
    int icnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] spk_vec();
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k] = ms[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mu[k] = 0;
            mr[k] = 0;
            ms[k] = 0;
        end
        mtick = 0;
        mhb = 0;
        icnt = 0;
    endtask

    task automatic model_step();
        int l, s, c, t;
        t = int'(thr);
        for (int k = 0; k < N; k++) begin
            c = int'(cur_in[k*W +: W]);
            if (mr[k] > 0) begin
                mr[k] = mr[k] - 1;
                ms[k] = 0;
            end else begin
                if (leak_mode == 2'd0)      l = mu[k] - mu[k] / (2 ** LS);
                else if (leak_mode == 2'd1) l = (mu[k] > LB) ? mu[k] - LB : 0;
                else                        l = mu[k];
                s = l + c;
                if (s > 255) s = 255;
                if (s >= t) begin
                    ms[k] = 1;
                    mr[k] = RF;
                    mu[k] = soft_reset ? s - t : 0;
                end else begin
                    ms[k] = 0;
                    mu[k] = s;
                end
            end
        end
    endtask

    task automatic cycle();
        bit st;
        st = ext_tick_en ? step_in : ((icnt % (DM + 1)) == DM);
        @(posedge clk);
        icnt = ext_tick_en ? 0 : icnt + 1;
        mtick = st;
        if (st) begin
            mhb = !mhb;
            model_step();
        end
        @(negedge clk);
        check("tick", 32'(tick), 32'(mtick));
        check("heartbeat", 32'(heartbeat), 32'(mhb));
        check("spike", 32'(spike), spk_vec());
    endtask

    task automatic ext_step();
        step_in = 1'b1;
        cycle();
        step_in = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_spike", 32'(spike), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_heartbeat", 32'(heartbeat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        icnt = 0;
    endtask

    task automatic set_in(input int c0, input int c1, input int c2, input int c3,
                          input int t, input int lm, input bit sr);
        cur_in = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
        thr = 8'(t);
        leak_mode = 2'(lm);
        soft_reset = sr;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("init_spike", 32'(spike), 32'd0);
        check("init_tick", 32'(tick), 32'd0);
        check("init_heartbeat", 32'(heartbeat), 32'd0);
        rst_n = 1'b1;

        // internal divider: tick every DM+1 cycles, first one on the 4th edge
        set_in(0, 0, 0, 0, 255, 2, 0);
        for (int i = 0; i < 12; i++) cycle();

        // integrate and fire, no leak, hard reset
        ext_tick_en = 1'b1;
        do_reset();
        set_in(4, 0, 0, 0, 10, 2, 0);
        ext_step();
        ext_step();
        ext_step();
        check("if_step3_spike0", 32'(spike[0]), 32'd1);
        for (int i = 0; i < 6; i++) ext_step();

        // shift leak with soft reset
        do_reset();
        set_in(0, 8, 0, 0, 10, 0, 1);
        ext_step();
        ext_step();
        check("shift_step2_spike1", 32'(spike[1]), 32'd1);
        for (int i = 0; i < 4; i++) ext_step();

        // refractory and saturation
        do_reset();
        set_in(0, 0, 200, 0, 255, 2, 0);
        ext_step();
        check("sat_step1_nospike", 32'(spike[2]), 32'd0);
        ext_step();
        check("sat_step2_spike2", 32'(spike[2]), 32'd1);
        for (int i = 0; i < 4; i++) ext_step();
        check("sat_step6_spike2", 32'(spike[2]), 32'd1);

        // subtract-leak floor, then thr=0
        do_reset();
        set_in(0, 0, 0, 0, 10, 1, 0);
        for (int i = 0; i < 3; i++) ext_step();
        check("floor_nospike", 32'(spike), 32'd0);
        thr = 8'd0;
        for (int i = 0; i < 6; i++) ext_step();

        // async reset while channel 0 is refractory with nonzero membrane
        do_reset();
        set_in(10, 0, 0, 0, 5, 2, 1);
        ext_step();
        ext_step();
        ext_tick_en = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        check("post_rst_spike0", 32'(spike[0]), 32'd1);

        // switching step source mid-period
        set_in(3, 5, 7, 9, 20, 0, 0);
        for (int i = 0; i < 6; i++) cycle();
        ext_tick_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_in = 1'($urandom_range(0, 1));
            cycle();
        end
        step_in = 1'b0;
        ext_tick_en = 1'b0;
        for (int i = 0; i < 10; i++) cycle();

        // randomized traffic with occasional async resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) ext_tick_en = ~ext_tick_en;
            step_in = 1'($urandom_range(0, 1));
            cur_in = N*W'($urandom());
            case ($urandom_range(0, 5))
                0:       thr = 8'd0;
                1:       thr = 8'd255;
                default: thr = 8'($urandom_range(0, 255));
            endcase
            leak_mode = 2'($urandom_range(0, 3));
            soft_reset = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) do_reset();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
